addroundkey_stream: RTL and testbench
=====================================

ADDROUNDKEY_STREAM -- requirements
Module: addroundkey_stream

Interface
REQ-001 SHALL have parameter BYTES_PER_BEAT, default 4; bytes of AES state per data beat; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10; last round index, so one schedule is NUM_ROUNDS+1 blocks.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port key_valid, input, 1 bit; round key offered.
REQ-006 SHALL have port key_ready, output, 1 bit; round key accepted when key_valid is also high.
REQ-007 SHALL have port key_in, input, 128 bits; round key, state byte i at bits [8i+7:8i].
REQ-008 SHALL have port in_valid, input, 1 bit; input beat offered.
REQ-009 SHALL have port in_ready, output, 1 bit; input beat accepted when in_valid is also high.
REQ-010 SHALL have port in_data, input, 8*BYTES_PER_BEAT bits; lane j of beat k is state byte k*BYTES_PER_BEAT+j.
REQ-011 SHALL have port out_valid, output, 1 bit; output beat present.
REQ-012 SHALL have port out_ready, input, 1 bit; output beat consumed when out_valid is also high.
REQ-013 SHALL have port out_data, output, 8*BYTES_PER_BEAT bits; XOR result, same lane mapping as in_data.
REQ-014 SHALL have port out_last, output, 1 bit; marks the final beat of a block.

Function
REQ-015 SHALL index state bytes column-major: byte i = 4*col + row.
REQ-016 SHALL set BEATS = 16/BYTES_PER_BEAT; the beat counter SHALL run 0..BEATS-1.
REQ-017 SHALL use the FSM states IDLE (no key), ARMED (key held, beat counter 0) and BUSY (block in progress).
REQ-018 SHALL drive key_ready = 1 only in IDLE; on a key handshake it SHALL register key_in and go to ARMED.
REQ-019 SHALL drive in_ready = (state is ARMED or BUSY) AND (out_valid = 0 OR out_ready = 1).
REQ-020 SHALL, on an input handshake in ARMED, go to BUSY; if BEATS = 1 it SHALL go straight to IDLE.
REQ-021 SHALL, on the input handshake of beat BEATS-1, clear the beat counter, discard the key and go to IDLE; each key covers exactly one block.
REQ-022 SHALL register out_data one cycle after an input handshake as in_data XOR the key bytes selected by the beat counter.
REQ-023 SHALL assert out_last with the beat BEATS-1 result.
REQ-024 SHALL hold out_data, out_last and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL sustain full throughput (one beat per cycle) while out_ready = 1.
REQ-026 SHALL ignore key_valid outside IDLE, with no change to the held key.
REQ-027 SHALL allow a new key to be accepted in the cycle after the last input beat, while that beat's output is still pending.

Reset
REQ-028 SHALL, on reset, set state IDLE, beat counter 0, key register 0, out_valid 0, out_data 0, out_last 0, round counter 0.
REQ-029 SHALL, on reset mid-block, abandon the block, drop the key and emit no further output beats.

Configuration
REQ-030 SHALL, with macro ADDROUNDKEY_ROUNDCNT_EN defined, add output round_idx ($clog2(NUM_ROUNDS+1) bits) and output out_final (1 bit), both aligned to out_data.
REQ-031 SHALL, with ADDROUNDKEY_ROUNDCNT_EN defined, increment the round counter on each completed block, wrapping from NUM_ROUNDS to 0; out_final = 1 when round_idx = NUM_ROUNDS.
REQ-032 SHALL, without ADDROUNDKEY_ROUNDCNT_EN, omit round_idx, out_final and the round counter; all other behaviour is identical.

Structure
REQ-033 SHALL place AES_BLOCK_BYTES = 16 and the FSM state enum in shared package aes_pkg.
REQ-034 SHALL implement the per-lane byte XOR in one combinational sub-module ark_lane_xor, instantiated once, BYTES_PER_BEAT lanes wide.

Verification
REQ-035 SHALL test BYTES_PER_BEAT = 16, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> out_data 00102030405060708090a0b0c0d0e0f0 with out_last = 1, one cycle after the handshake.
REQ-036 SHALL test BYTES_PER_BEAT = 4 with the same vectors -> four beats 00102030, 40506070, 8090a0b0, c0d0e0f0 (byte 0 lowest), out_last on beat 3 only.
REQ-037 SHALL test out_ready held 0 for 5 cycles mid-block -> out_data stable, in_ready = 0, no beat lost or duplicated.
REQ-038 SHALL test key_valid pulsed during BUSY with key all-FF -> key_ready = 0 and the block still uses the original key.
REQ-039 SHALL test reset asserted after beat 1 of 4 -> out_valid = 0 the next cycle, key_ready = 1, and the next key plus block produce correct output.
REQ-040 SHALL test, with ADDROUNDKEY_ROUNDCNT_EN and NUM_ROUNDS = 10, 12 consecutive blocks -> round_idx 0..10 then 0, and out_final only on the block with round_idx = 10.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES constants and the state encoding of the streaming AddRoundKey
// controller.
//   AES_BLOCK_BYTES : bytes in one AES state block (16)
//   ark_state_t     : IDLE (no key), ARMED (key held, no beat taken yet),
//                     BUSY (block in progress)
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLOCK_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      BUSY  = 2'd2
   } ark_state_t;

endpackage

// File: rtl/ark_lane_xor.sv
// -----------------------------------------------------------------------------
// ark_lane_xor
// Combinational byte-lane XOR of one data beat with the matching round-key
// bytes.
// Parameters:
//   LANES  : number of byte lanes in the beat
// Ports:
//   data   : input  [8*LANES-1:0] data beat, lane j at bits [8j+7:8j]
//   key    : input  [8*LANES-1:0] key bytes for this beat, same lane order
//   result : output [8*LANES-1:0] data XOR key, lane by lane
// -----------------------------------------------------------------------------
module ark_lane_xor #(
   parameter int LANES = 4
) (
   input  logic [8*LANES-1:0] data,
   input  logic [8*LANES-1:0] key,
   output logic [8*LANES-1:0] result
);

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign result[8*j +: 8] = data[8*j +: 8] ^ key[8*j +: 8];
   end

endmodule

// File: rtl/addroundkey_stream.sv
// -----------------------------------------------------------------------------
// addroundkey_stream
// Streaming AES AddRoundKey. A 128-bit round key is accepted once, then one
// 16-byte block arrives as 16/BYTES_PER_BEAT beats; each beat is XORed with
// the key bytes it covers and registered out. Every key is used for exactly
// one block and is then discarded.
//
// Optional feature (macro ADDROUNDKEY_ROUNDCNT_EN): a round counter tags each
// output beat with round_idx and raises out_final on round NUM_ROUNDS.
//
// Parameters:
//   BYTES_PER_BEAT : bytes per beat (1, 2, 4, 8, 16)
//   NUM_ROUNDS     : last round index (schedule is NUM_ROUNDS+1 blocks)
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   key_valid/key_ready   : round key handshake, key_in[8i+7:8i] = byte i
//   in_valid/in_ready     : input beat handshake, in_data lane j = byte
//                           k*BYTES_PER_BEAT+j of beat k
//   out_valid/out_ready   : output beat handshake
//   out_data, out_last    : XOR result and final-beat-of-block flag
//   round_idx, out_final  : (macro only) round tag aligned to out_data
// -----------------------------------------------------------------------------
module addroundkey_stream
   import aes_pkg::*;
#(
   parameter int BYTES_PER_BEAT = 4,
   parameter int NUM_ROUNDS     = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          key_valid,
   output logic                          key_ready,
   input  logic [127:0]                  key_in,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [8*BYTES_PER_BEAT-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [8*BYTES_PER_BEAT-1:0]   out_data,
   output logic                          out_last
`ifdef ADDROUNDKEY_ROUNDCNT_EN
   ,
   output logic [$clog2(NUM_ROUNDS+1)-1:0] round_idx,
   output logic                            out_final
`endif
);

   localparam int BEATS  = AES_BLOCK_BYTES / BYTES_PER_BEAT;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LANE_W = 8 * BYTES_PER_BEAT;

   ark_state_t          state, state_nxt;
   logic [CNT_W-1:0]    beat_cnt;
   logic [127:0]        key_q;
   logic [LANE_W-1:0]   key_sel;
   logic [LANE_W-1:0]   xor_p0;
   logic                key_hs;
   logic                in_hs;
   logic                last_beat;

   // Key bytes for the current beat; beat k covers bytes k*BYTES_PER_BEAT upward.
   assign key_sel   = key_q[int'(beat_cnt) * LANE_W +: LANE_W];
   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
   assign key_hs    = key_valid & key_ready;
   assign in_hs     = in_valid & in_ready;

   ark_lane_xor #(
      .LANES (BYTES_PER_BEAT)
   ) u_xor (
      .data   (in_data),
      .key    (key_sel),
      .result (xor_p0)
   );

   always_comb begin
      state_nxt = state;
      key_ready = (state == IDLE);
      // Accept a beat only if the output register is free or being drained.
      in_ready  = (state != IDLE) && (!out_valid || out_ready);
      case (state)
         IDLE:    if (key_hs) state_nxt = ARMED;
         ARMED:   if (in_hs)  state_nxt = last_beat ? IDLE : BUSY;
         BUSY:    if (in_hs && last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stage p0 -> output register
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt  <= '0;
         key_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (key_hs) begin
            key_q <= key_in;
         end
         if (in_hs) begin
            if (last_beat) begin
               // Block complete: the key has served its one block.
               beat_cnt <= '0;
               key_q    <= '0;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
            out_data  <= xor_p0;
            out_last  <= last_beat;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef ADDROUNDKEY_ROUNDCNT_EN
   localparam int RW = $clog2(NUM_ROUNDS + 1);

   logic [RW-1:0] rnd_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         rnd_cnt   <= '0;
         round_idx <= '0;
         out_final <= 1'b0;
      end else if (in_hs) begin
         round_idx <= rnd_cnt;
         out_final <= (rnd_cnt == RW'(NUM_ROUNDS));
         if (last_beat) begin
            rnd_cnt <= (rnd_cnt == RW'(NUM_ROUNDS)) ? '0 : rnd_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_addroundkey_stream.sv
// -----------------------------------------------------------------------------
// tb_addroundkey_stream
// Two instances: A with 4-byte beats, B with 16-byte beats. Stimulus tasks
// push expected beats into per-instance queues; monitors pop and compare on
// every output handshake. Round tagging is checked when
// ADDROUNDKEY_ROUNDCNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_addroundkey_stream;

   localparam int NR = 10;

   typedef struct {
      logic [127:0] d;
      logic         last;
      int           rnd;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: 4 bytes per beat
   logic         a_key_valid, a_key_ready, a_in_valid, a_in_ready;
   logic         a_out_valid, a_out_ready, a_out_last;
   logic [127:0] a_key_in;
   logic [31:0]  a_in_data, a_out_data;
   // Instance B: 16 bytes per beat
   logic         b_key_valid, b_key_ready, b_in_valid, b_in_ready;
   logic         b_out_valid, b_out_ready, b_out_last;
   logic [127:0] b_key_in, b_in_data, b_out_data;
`ifdef ADDROUNDKEY_ROUNDCNT_EN
   logic [3:0]   a_round_idx, b_round_idx;
   logic         a_out_final, b_out_final;
`endif

   addroundkey_stream #(.BYTES_PER_BEAT(4), .NUM_ROUNDS(NR)) dut_a (
      .clk(clk), .reset(reset),
      .key_valid(a_key_valid), .key_ready(a_key_ready), .key_in(a_key_in),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_last(a_out_last)
`ifdef ADDROUNDKEY_ROUNDCNT_EN
      , .round_idx(a_round_idx), .out_final(a_out_final)
`endif
   );

   addroundkey_stream #(.BYTES_PER_BEAT(16), .NUM_ROUNDS(NR)) dut_b (
      .clk(clk), .reset(reset),
      .key_valid(b_key_valid), .key_ready(b_key_ready), .key_in(b_key_in),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_last(b_out_last)
`ifdef ADDROUNDKEY_ROUNDCNT_EN
      , .round_idx(b_round_idx), .out_final(b_out_final)
`endif
   );

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t a_q[$];
   exp_t b_q[$];
   int   a_blk = 0;
   int   b_blk = 0;
   int   a_rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   // Reference AddRoundKey: state byte i of the result is data byte i XOR key byte i.
   function automatic logic [127:0] ark_ref(input logic [127:0] key, input logic [127:0] data);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = data[8*i +: 8] ^ key[8*i +: 8];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Queue the expected beats of a block; only whole blocks advance the round.
   task automatic a_push(input logic [127:0] key, input logic [127:0] data, input int nbeats);
      logic [127:0] r;
      exp_t e;
      r = ark_ref(key, data);
      for (int k = 0; k < nbeats; k++) begin
         e.d    = {96'd0, r[32*k +: 32]};
         e.last = (k == 3);
         e.rnd  = a_blk % (NR + 1);
         a_q.push_back(e);
      end
      if (nbeats == 4) a_blk++;
   endtask

   task automatic b_push(input logic [127:0] key, input logic [127:0] data);
      exp_t e;
      e.d    = ark_ref(key, data);
      e.last = 1'b1;
      e.rnd  = b_blk % (NR + 1);
      b_q.push_back(e);
      b_blk++;
   endtask

   task automatic a_send_key(input logic [127:0] key);
      logic hs;
      bit   done = 0;
      a_key_in    = key;
      a_key_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk); hs = a_key_valid && a_key_ready;
         @(posedge clk); #1;
         if (hs) done = 1;
      end
      if (!done) fail_now("a_key_timeout");
      a_key_valid = 1'b0;
   endtask

   task automatic b_send_key(input logic [127:0] key);
      logic hs;
      bit   done = 0;
      b_key_in    = key;
      b_key_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk); hs = b_key_valid && b_key_ready;
         @(posedge clk); #1;
         if (hs) done = 1;
      end
      if (!done) fail_now("b_key_timeout");
      b_key_valid = 1'b0;
   endtask

   task automatic a_drive_block(input logic [127:0] data, input int nbeats, input int maxgap);
      logic hs;
      bit   done;
      for (int k = 0; k < nbeats; k++) begin
         if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
         a_in_data  = data[32*k +: 32];
         a_in_valid = 1'b1;
         done = 0;
         for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk); hs = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (hs) done = 1;
         end
         a_in_valid = 1'b0;
         if (!done) begin
            fail_now("a_in_timeout");
            return;
         end
         check("a_latency_valid", a_out_valid, 1'b1);
         check("a_latency_last", a_out_last, (k == 3));
      end
      if (nbeats == 4) begin
         // A fresh key must be acceptable right after the last beat.
         @(negedge clk);
         check("a_key_ready_after_last", a_key_ready, 1'b1);
         @(posedge clk); #1;
      end
   endtask

   task automatic b_drive_block(input logic [127:0] data, input logic check_now, input logic [127:0] exp);
      logic hs;
      bit   done = 0;
      b_in_data  = data;
      b_in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk); hs = b_in_valid && b_in_ready;
         @(posedge clk); #1;
         if (hs) done = 1;
      end
      b_in_valid = 1'b0;
      if (!done) begin
         fail_now("b_in_timeout");
         return;
      end
      check("b_latency_valid", b_out_valid, 1'b1);
      check("b_latency_last", b_out_last, 1'b1);
      if (check_now) check("b_latency_data", b_out_data, exp);
   endtask

   // out_ready driver for A
   initial begin
      a_out_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (a_rdy_mode)
            0:       a_out_ready = 1'b1;
            1:       a_out_ready = ($urandom_range(3, 0) != 0);
            default: a_out_ready = 1'b0;
         endcase
      end
   end

   // Monitor A: scoreboard pop on handshake, hold/backpressure checks on stall
   logic        a_prev_stall = 1'b0;
   logic [31:0] a_prev_data;
   logic        a_prev_last;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         a_prev_stall = 1'b0;
      end else begin
         if (a_prev_stall) begin
            check("a_hold_valid", a_out_valid, 1'b1);
            check("a_hold_data", a_out_data, a_prev_data);
            check("a_hold_last", a_out_last, a_prev_last);
         end
         if (a_out_valid && !a_out_ready) check("a_stall_in_ready", a_in_ready, 1'b0);
         if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
               fail_now("a_unexpected_beat");
            end else begin
               e = a_q.pop_front();
               check("a_out_data", a_out_data, e.d);
               check("a_out_last", a_out_last, e.last);
`ifdef ADDROUNDKEY_ROUNDCNT_EN
               check("a_round_idx", a_round_idx, e.rnd);
               check("a_out_final", a_out_final, (e.rnd == NR));
`endif
            end
         end
         a_prev_stall = a_out_valid && !a_out_ready;
         a_prev_data  = a_out_data;
         a_prev_last  = a_out_last;
      end
   end

   // Monitor B
   always @(negedge clk) begin
      exp_t e;
      if (!reset && b_out_valid && b_out_ready) begin
         if (b_q.size() == 0) begin
            fail_now("b_unexpected_beat");
         end else begin
            e = b_q.pop_front();
            check("b_out_data", b_out_data, e.d);
            check("b_out_last", b_out_last, e.last);
`ifdef ADDROUNDKEY_ROUNDCNT_EN
            check("b_round_idx", b_round_idx, e.rnd);
            check("b_out_final", b_out_final, (e.rnd == NR));
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] vkey, vdat, k, d;
      time t0;
      vkey = 128'h0f0e0d0c0b0a09080706050403020100;   // byte i = i
      vdat = 128'hffeeddccbbaa99887766554433221100;   // byte i = 0x11*i
      reset = 1'b1;
      a_key_valid = 0; a_in_valid = 0; a_key_in = '0; a_in_data = '0;
      b_key_valid = 0; b_in_valid = 0; b_key_in = '0; b_in_data = '0;
      b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_a_key_ready", a_key_ready, 1'b1);
      check("rst_a_in_ready", a_in_ready, 1'b0);
      check("rst_a_out_valid", a_out_valid, 1'b0);
      check("rst_a_out_data", a_out_data, 32'h0);
      check("rst_a_out_last", a_out_last, 1'b0);
      check("rst_b_out_valid", b_out_valid, 1'b0);
      check("rst_b_out_data", b_out_data, 128'h0);
      @(posedge clk); #1;

      // 16-byte beat known-answer vector
      b_q.push_back('{d: 128'hf0e0d0c0b0a090807060504030201000, last: 1'b1, rnd: b_blk % (NR + 1)});
      b_blk++;
      b_send_key(vkey);
      b_drive_block(vdat, 1'b1, 128'hf0e0d0c0b0a090807060504030201000);
      for (int n = 0; n < 4; n++) begin
         k = rand128(); d = rand128();
         b_send_key(k);
         b_push(k, d);
         b_drive_block(d, 1'b0, '0);
      end

      // 4-byte beat known-answer vector, one beat per cycle
      a_q.push_back('{d: 128'h30201000, last: 1'b0, rnd: a_blk % (NR + 1)});
      a_q.push_back('{d: 128'h70605040, last: 1'b0, rnd: a_blk % (NR + 1)});
      a_q.push_back('{d: 128'hb0a09080, last: 1'b0, rnd: a_blk % (NR + 1)});
      a_q.push_back('{d: 128'hf0e0d0c0, last: 1'b1, rnd: a_blk % (NR + 1)});
      a_blk++;
      a_send_key(vkey);
      t0 = $time;
      a_drive_block(vdat, 4, 0);
      // four beats plus the trailing key_ready look
      check("a_throughput_cycles", ($time - t0) / 10, 5);

      // Back-pressure for 5 cycles in the middle of a block
      k = rand128(); d = rand128();
      a_send_key(k);
      a_push(k, d, 4);
      fork
         a_drive_block(d, 4, 0);
         begin
            repeat (2) @(posedge clk);
            a_rdy_mode = 2;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("a_stall_in_ready_mid", a_in_ready, 1'b0);
            check("a_stall_out_valid_mid", a_out_valid, 1'b1);
            repeat (2) @(posedge clk);
            a_rdy_mode = 0;
         end
      join

      // Key offered while busy must be refused and leave the held key untouched
      k = rand128(); d = rand128();
      a_send_key(k);
      a_push(k, d, 4);
      fork
         a_drive_block(d, 4, 0);
         begin
            @(posedge clk); #1;
            a_key_in    = {128{1'b1}};
            a_key_valid = 1'b1;
            @(negedge clk);
            check("a_key_ready_busy", a_key_ready, 1'b0);
            @(posedge clk); #1;
            a_key_valid = 1'b0;
         end
      join

      // Randomized blocks with random gaps and random output back-pressure
      a_rdy_mode = 1;
      for (int n = 0; n < 14; n++) begin
         k = rand128(); d = rand128();
         a_send_key(k);
         a_push(k, d, 4);
         a_drive_block(d, 4, 2);
      end
      a_rdy_mode = 0;
      repeat (4) @(posedge clk);
      #1;

      // Reset after beat 1 of 4
      k = rand128(); d = rand128();
      a_send_key(k);
      a_push(k, d, 2);
      a_drive_block(d, 2, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      a_q.delete();
      b_q.delete();
      a_blk = 0;
      b_blk = 0;
      check("a_reset_out_valid", a_out_valid, 1'b0);
      check("a_reset_key_ready", a_key_ready, 1'b1);
      check("a_reset_in_ready", a_in_ready, 1'b0);
      for (int n = 0; n < 3; n++) begin
         k = rand128(); d = rand128();
         a_send_key(k);
         a_push(k, d, 4);
         a_drive_block(d, 4, 1);
      end

      // Drain
      for (int t = 0; t < 100 && (a_q.size() != 0 || b_q.size() != 0); t++) @(posedge clk);
      @(negedge clk);
      check("a_queue_drained", a_q.size(), 0);
      check("b_queue_drained", b_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
